// File: rtl/mem_data_controller.sv
// MEM-stage data-memory controller: issues word-addressed load/store requests,
// lane-aligns store data and load results, and stalls the stage while memory is busy.
module mem_data_controller #(
  parameter int ADDR_W     = 30,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              M_Flush,
  input  logic              M_StallOther,
  input  logic              M_MemRead,
  input  logic              M_MemWrite,
  input  logic              M_MemByte,
  input  logic              M_MemHalf,
  input  logic              M_MemSignExtend,
  input  logic [31:0]       M_Address,
  input  logic [31:0]       M_WriteData,
  input  logic [31:0]       DataMem_In,
  input  logic              DataMem_Ready,
  output logic              DataMem_Read,
  output logic [3:0]        DataMem_Write,
  output logic [ADDR_W-1:0] DataMem_Address,
  output logic [31:0]       DataMem_Out,
  output logic [31:0]       M_ReadData,
  output logic              M_Stall,
  output logic              M_AddrErrLoad,
  output logic              M_AddrErrStore
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t state, state_nxt;

  logic              is_byte, is_half, is_word, access, misaligned, issue;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic              capture_hold;

  logic              r_read;
  logic [3:0]        r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_byte, r_half, r_sign;
  logic [1:0]        r_off;
  logic [31:0]       hold_data;

  function automatic logic [1:0] byte_lane(input logic [1:0] off);
    return BIG_ENDIAN ? ~off : off;
  endfunction

  function automatic logic half_lane(input logic off1);
    return BIG_ENDIAN ? ~off1 : off1;
  endfunction

  function automatic logic [31:0] align_load(input logic [31:0] d, input logic b, input logic h,
                                             input logic s, input logic [1:0] off);
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] r;
    bv = 8'(d >> {byte_lane(off), 3'b000});
    hv = 16'(d >> {half_lane(off[1]), 4'b0000});
    if (b)      r = {{24{s & bv[7]}}, bv};
    else if (h) r = {{16{s & hv[15]}}, hv};
    else        r = d;
    return r;
  endfunction

  assign is_byte    = M_MemByte;
  assign is_half    = M_MemHalf & ~M_MemByte;
  assign is_word    = ~M_MemByte & ~M_MemHalf;
  assign access     = M_MemRead | M_MemWrite;
  assign misaligned = (is_half & M_Address[0]) | (is_word & (M_Address[1:0] != 2'b00));
  // Reset gates issue so an asserted reset drops the request immediately.
  assign issue      = access & ~misaligned & ~M_Flush & reset;

  assign M_AddrErrLoad  = M_MemRead  & misaligned & ~M_Flush;
  assign M_AddrErrStore = M_MemWrite & misaligned & ~M_Flush;

  assign be = is_word ? 4'b1111 :
              is_half ? (half_lane(M_Address[1]) ? 4'b1100 : 4'b0011) :
                        (4'b0001 << byte_lane(M_Address[1:0]));
  assign wdata_rep = is_byte ? {4{M_WriteData[7:0]}} :
                     is_half ? {2{M_WriteData[15:0]}} : M_WriteData;

  always_comb begin
    state_nxt       = state;
    DataMem_Read    = 1'b0;
    DataMem_Write   = 4'b0000;
    DataMem_Address = M_Address[ADDR_W+1:2];
    DataMem_Out     = wdata_rep;
    M_ReadData      = align_load(DataMem_In, is_byte, is_half, M_MemSignExtend, M_Address[1:0]);
    M_Stall         = 1'b0;
    capture_hold    = 1'b0;
    case (state)
      S_IDLE: if (issue) begin
        DataMem_Read  = M_MemRead;
        DataMem_Write = M_MemWrite ? be : 4'b0000;
        if (DataMem_Ready) begin
          capture_hold = M_StallOther;
          state_nxt    = M_StallOther ? S_HOLD : S_IDLE;
        end else begin
          M_Stall   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Flush does not cancel an outstanding request; it always runs to completion.
        DataMem_Read    = r_read;
        DataMem_Write   = r_write;
        DataMem_Address = r_addr;
        DataMem_Out     = r_data;
        M_ReadData      = align_load(DataMem_In, r_byte, r_half, r_sign, r_off);
        if (DataMem_Ready) begin
          capture_hold = M_StallOther;
          state_nxt    = M_StallOther ? S_HOLD : S_IDLE;
        end else begin
          M_Stall = 1'b1;
        end
      end
      S_HOLD: begin
        // Nothing is re-issued while the pipeline is held, so a store is never repeated.
        DataMem_Address = r_addr;
        DataMem_Out     = r_data;
        M_ReadData      = hold_data;
        if (!M_StallOther) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      r_read    <= 1'b0;
      r_write   <= 4'b0000;
      r_addr    <= '0;
      r_data    <= '0;
      r_byte    <= 1'b0;
      r_half    <= 1'b0;
      r_sign    <= 1'b0;
      r_off     <= 2'b00;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && issue) begin
        r_read  <= M_MemRead;
        r_write <= M_MemWrite ? be : 4'b0000;
        r_addr  <= M_Address[ADDR_W+1:2];
        r_data  <= wdata_rep;
        r_byte  <= is_byte;
        r_half  <= is_half;
        r_sign  <= M_MemSignExtend;
        r_off   <= M_Address[1:0];
      end
      if (capture_hold) hold_data <= M_ReadData;
    end
  end
endmodule

// File: tb/tb_mem_data_controller.sv
// Directed bench for mem_data_controller: a transaction-level model checked every
// cycle, plus per-cycle hand-computed literal expectations.
module tb_mem_data_controller;
  localparam bit BE = 1'b1;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_Flush, M_StallOther, M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend;
  logic [31:0] M_Address, M_WriteData, DataMem_In;
  logic        DataMem_Ready;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out, M_ReadData;
  logic        M_Stall, M_AddrErrLoad, M_AddrErrStore;

  mem_data_controller #(.ADDR_W(30), .BIG_ENDIAN(BE)) dut (
    .clock(clock), .reset(reset), .M_Flush(M_Flush), .M_StallOther(M_StallOther),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemByte(M_MemByte),
    .M_MemHalf(M_MemHalf), .M_MemSignExtend(M_MemSignExtend), .M_Address(M_Address),
    .M_WriteData(M_WriteData), .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready),
    .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out), .M_ReadData(M_ReadData),
    .M_Stall(M_Stall), .M_AddrErrLoad(M_AddrErrLoad), .M_AddrErrStore(M_AddrErrStore));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Literal expectations for the current cycle, written only by the stimulus process.
  localparam int S_RD = 0, S_READ = 1, S_WR = 2, S_ADDR = 3, S_OUT = 4, S_STALL = 5, S_ADEL = 6, S_ADES = 7;
  string       lit_name [8];
  int          lit_sel  [8];
  logic [31:0] lit_exp  [8];
  int          lit_cnt = 0;

  // Model state: an outstanding request and/or a held load result.
  logic        pend, held;
  logic        p_read, p_b, p_h, p_s;
  logic [3:0]  p_we;
  logic [31:0] p_addr, p_out, h_val;
  logic [1:0]  p_off;
  logic        n_pend, n_held, n_read, n_b, n_h, n_s;
  logic [3:0]  n_we;
  logic [31:0] n_addr, n_out, n_hval;
  logic [1:0]  n_off;

  function automatic int sh_byte(input logic [1:0] off);
    return BE ? (3 - int'(off)) * 8 : int'(off) * 8;
  endfunction
  function automatic int sh_half(input logic [1:0] off);
    return BE ? (2 - int'(off & 2'b10)) * 8 : int'(off & 2'b10) * 8;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] d, input logic b, input logic h,
                                         input logic s, input logic [1:0] off);
    logic [31:0] v;
    if (b) begin
      v = (d >> sh_byte(off)) & 32'hFF;
      if (s && v[7]) v = v | 32'hFFFF_FF00;
    end else if (h) begin
      v = (d >> sh_half(off)) & 32'hFFFF;
      if (s && v[15]) v = v | 32'hFFFF_0000;
    end else v = d;
    return v;
  endfunction

  function automatic logic [3:0] m_lanes(input logic b, input logic h, input logic [1:0] off);
    if (b) return 4'(1 << (sh_byte(off) / 8));
    if (h) return 4'(3 << (sh_half(off) / 8));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_rep(input logic [31:0] wd, input logic b, input logic h);
    if (b) return {4{wd[7:0]}};
    if (h) return {2{wd[15:0]}};
    return wd;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_sig(input int sel);
    case (sel)
      S_RD:    return M_ReadData;
      S_READ:  return {31'd0, DataMem_Read};
      S_WR:    return {28'd0, DataMem_Write};
      S_ADDR:  return {2'b00, DataMem_Address};
      S_OUT:   return DataMem_Out;
      S_STALL: return {31'd0, M_Stall};
      S_ADEL:  return {31'd0, M_AddrErrLoad};
      default: return {31'd0, M_AddrErrStore};
    endcase
  endfunction

  // Compare process: model outputs from the request/hold bookkeeping and current inputs.
  always @(negedge clock) begin
    logic b, h, word, mis, iss, e_read, e_stall, done;
    logic [3:0] e_we;
    logic [31:0] e_addr, e_out, e_rd;
    b = M_MemByte; h = M_MemHalf & ~M_MemByte; word = ~M_MemByte & ~M_MemHalf;
    mis = (h && (M_Address % 2 != 0)) || (word && (M_Address % 4 != 0));
    iss = (M_MemRead | M_MemWrite) & ~mis & ~M_Flush & reset;
    chk("adel", {31'd0, M_AddrErrLoad},  {31'd0, M_MemRead  & mis & ~M_Flush});
    chk("ades", {31'd0, M_AddrErrStore}, {31'd0, M_MemWrite & mis & ~M_Flush});
    n_read = p_read; n_we = p_we; n_addr = p_addr; n_out = p_out;
    n_b = p_b; n_h = p_h; n_s = p_s; n_off = p_off; n_hval = h_val;
    e_rd = 32'd0; done = 1'b0;
    if (pend) begin
      e_read = p_read; e_we = p_we; e_addr = p_addr; e_out = p_out;
      e_stall = ~DataMem_Ready; done = DataMem_Ready;
      e_rd = m_load(DataMem_In, p_b, p_h, p_s, p_off);
      n_pend = ~DataMem_Ready;
    end else if (held) begin
      e_read = 1'b0; e_we = 4'd0; e_addr = 32'd0; e_out = 32'd0; e_stall = 1'b0;
      e_rd = h_val;
      n_pend = 1'b0;
    end else begin
      e_read = iss & M_MemRead;
      e_we = (iss & M_MemWrite) ? m_lanes(b, h, M_Address[1:0]) : 4'd0;
      e_addr = M_Address >> 2; e_out = m_rep(M_WriteData, b, h);
      e_stall = iss & ~DataMem_Ready; done = iss & DataMem_Ready;
      e_rd = m_load(DataMem_In, b, h, M_MemSignExtend, M_Address[1:0]);
      n_pend = iss & ~DataMem_Ready;
      n_read = M_MemRead; n_we = e_we; n_addr = e_addr; n_out = e_out;
      n_b = b; n_h = h; n_s = M_MemSignExtend; n_off = M_Address[1:0];
    end
    chk("read",  {31'd0, DataMem_Read}, {31'd0, e_read});
    chk("write", {28'd0, DataMem_Write}, {28'd0, e_we});
    chk("stall", {31'd0, M_Stall}, {31'd0, e_stall});
    if (e_read || e_we != 4'd0) begin
      chk("addr", {2'b00, DataMem_Address}, e_addr);
      chk("wdata", DataMem_Out, e_out);
    end
    if (done || held) chk("rdata", M_ReadData, e_rd);
    if (done && M_StallOther) begin n_held = 1'b1; n_hval = e_rd; end
    else n_held = held & M_StallOther;
    for (int i = 0; i < lit_cnt; i++) chk(lit_name[i], dut_sig(lit_sel[i]), lit_exp[i]);
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0; held <= 1'b0; p_read <= 1'b0; p_we <= 4'd0; p_addr <= 32'd0;
      p_out <= 32'd0; p_b <= 1'b0; p_h <= 1'b0; p_s <= 1'b0; p_off <= 2'd0; h_val <= 32'd0;
    end else begin
      pend <= n_pend; held <= n_held; p_read <= n_read; p_we <= n_we; p_addr <= n_addr;
      p_out <= n_out; p_b <= n_b; p_h <= n_h; p_s <= n_s; p_off <= n_off; h_val <= n_hval;
    end
  end

  task automatic lit(input string n, input int sel, input logic [31:0] e);
    lit_name[lit_cnt] = n; lit_sel[lit_cnt] = sel; lit_exp[lit_cnt] = e; lit_cnt++;
  endtask

  task automatic step();
    @(posedge clock); #1;
    lit_cnt = 0;
  endtask

  task automatic idle_in();
    M_Flush = 0; M_StallOther = 0; M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0;
    M_MemHalf = 0; M_MemSignExtend = 0; M_Address = 0; M_WriteData = 0;
    DataMem_In = 0; DataMem_Ready = 0;
  endtask

  task automatic acc(input logic rd, input logic wr, input logic b, input logic h,
                     input logic s, input logic [31:0] a, input logic [31:0] wd);
    M_MemRead = rd; M_MemWrite = wr; M_MemByte = b; M_MemHalf = h;
    M_MemSignExtend = s; M_Address = a; M_WriteData = wd;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    #2;
    lit("rst_stall", S_STALL, 0); lit("rst_read", S_READ, 0); lit("rst_write", S_WR, 0);
    step(); step();
    reset = 1'b1;
    step();

    // Byte load, sign-extended, zero-wait memory.
    acc(1, 0, 1, 0, 1, 32'h1003, 0); DataMem_In = 32'h1122_33F0; DataMem_Ready = 1;
    lit("t1_rd", S_RD, 32'hFFFF_FFF0); lit("t1_stall", S_STALL, 0);
    lit("t1_addr", S_ADDR, 32'h400); lit("t1_read", S_READ, 1);
    step(); idle_in();

    // Half store, memory answers on the 4th cycle; flush mid-wait must not cancel it.
    acc(0, 1, 0, 1, 0, 32'h2002, 32'h0000_ABCD);
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) M_WriteData = 32'h0000_1234;
      if (c >= 2) M_Flush = 1;
      if (c == 3) DataMem_Ready = 1;
      lit("t2_we", S_WR, 32'h3); lit("t2_out", S_OUT, 32'hABCD_ABCD);
      lit("t2_stall", S_STALL, (c < 3) ? 32'd1 : 32'd0);
      step();
    end
    idle_in();

    // Byte store, zero-wait.
    acc(0, 1, 1, 0, 0, 32'h3001, 32'h0000_005A); DataMem_Ready = 1;
    lit("t2b_we", S_WR, 32'h4); lit("t2b_out", S_OUT, 32'h5A5A_5A5A);
    step(); idle_in();

    // Misaligned accesses and flush suppression.
    acc(1, 0, 0, 0, 0, 32'h6, 0);
    lit("t3_adel", S_ADEL, 1); lit("t3_read", S_READ, 0); lit("t3_stall", S_STALL, 0);
    step();
    M_Flush = 1; lit("t3_adel_fl", S_ADEL, 0);
    step(); idle_in();
    acc(0, 1, 0, 1, 0, 32'h101, 32'h77); lit("t3_ades", S_ADES, 1); lit("t3_we", S_WR, 0);
    step(); idle_in();

    // Load completing under an external stall: result held, no re-issue.
    acc(1, 0, 0, 0, 0, 32'h20, 0); DataMem_In = 32'hDEAD_BEEF; DataMem_Ready = 1; M_StallOther = 1;
    lit("t4_rd0", S_RD, 32'hDEAD_BEEF);
    step();
    DataMem_Ready = 0; DataMem_In = 32'h0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) M_StallOther = 0;
      lit("t4_hold_rd", S_RD, 32'hDEAD_BEEF); lit("t4_noreq", S_READ, 0); lit("t4_stall", S_STALL, 0);
      step();
    end
    acc(1, 0, 1, 0, 0, 32'h21, 0); DataMem_In = 32'h00A5_0000; DataMem_Ready = 1;
    lit("t4_reissue", S_READ, 1); lit("t4_rd1", S_RD, 32'h0000_00A5);
    step(); idle_in();

    // Reset while waiting drops the request asynchronously.
    acc(1, 0, 0, 1, 0, 32'h10, 0);
    lit("t5_stall0", S_STALL, 1);
    step(); step();
    reset = 1'b0;
    lit("t5_rst_read", S_READ, 0); lit("t5_rst_stall", S_STALL, 0);
    step();
    reset = 1'b1;
    DataMem_In = 32'h8001_0000; DataMem_Ready = 1;
    lit("t5_rd", S_RD, 32'h0000_8001); lit("t5_read", S_READ, 1); lit("t5_stall", S_STALL, 0);
    step(); idle_in();
    step(); step();
    @(negedge clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
